unflattening_layer: RTL and testbench
=====================================

UNFLATTENING_LAYER -- requirements
Module: unflattening_layer

Interface
REQ-001 SHALL have parameter BitSize, default 4: width of one pixel.
REQ-002 SHALL have parameter ImageSize, default 4: pixels per image vector.
REQ-003 SHALL have parameter NumOfImages, default 4: images per frame.
REQ-004 SHALL have parameter NumOfInputs, default 2: parallel output lanes.
REQ-005 SHALL have parameter CyclesPerPixel, default 2: output cycles per pixel index, with CyclesPerPixel*NumOfInputs >= NumOfImages.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-007 SHALL have port res_n, input, 1 bit: reset, asynchronous and active-low.
REQ-008 SHALL have port in_valid, input, 1 bit: in_data holds one image.
REQ-009 SHALL have port in_ready, output, 1 bit: block accepts an image this cycle.
REQ-010 SHALL have port in_data, input, [ImageSize-1:0][BitSize-1:0]: one image vector.
REQ-011 SHALL have port out_stall, input, 1 bit: freeze output sequencing.
REQ-012 SHALL have port out_valid, output, [NumOfImages-1:0]: bit n means image n's pixel is on a lane.
REQ-013 SHALL have port out_data, output, [NumOfInputs-1:0][BitSize-1:0]: lane pixels.
REQ-014 SHALL have port frame_done, output, 1 bit: one-cycle pulse on the last send cycle of a frame.

Function
REQ-015 SHALL implement FSM states LOAD and SEND.
REQ-016 In LOAD, in_ready SHALL be 1, out_valid 0 and out_data 0.
REQ-017 In LOAD, each in_valid&in_ready edge SHALL store in_data as image k, where k is the image counter 0..NumOfImages-1, and increment k.
REQ-018 The accept of image NumOfImages-1 SHALL move the FSM to SEND and clear k.
REQ-019 In SEND, in_ready SHALL be 0 and in_valid SHALL be ignored.
REQ-020 SEND SHALL step pixel index p from ImageSize-1 down to 0; for each p, cycle index c SHALL run 0..CyclesPerPixel-1.
REQ-021 In send cycle (p,c), lane l SHALL carry pixel p of image c*NumOfInputs+l, with out_valid for that image set, if the image index < NumOfImages; otherwise the lane SHALL be 0 with no valid bit.
REQ-022 A cycle whose c*NumOfInputs >= NumOfImages SHALL be emitted with out_valid=0 and still count toward the sequence.
REQ-023 out_valid and out_data SHALL be decoded from registered state.
REQ-024 The first send cycle SHALL be the cycle immediately after the final accept edge.
REQ-025 An unstalled frame SHALL occupy exactly ImageSize*CyclesPerPixel SEND cycles.
REQ-026 While out_stall=1 in SEND, p and c SHALL hold and outputs SHALL repeat; frame_done SHALL be suppressed.
REQ-027 out_stall SHALL have no effect in LOAD.
REQ-028 frame_done SHALL be 1 only in cycle (p=0, c=CyclesPerPixel-1) with out_stall=0.
REQ-029 On the edge ending that cycle, the FSM SHALL return to LOAD with p=ImageSize-1 and c=0.
REQ-030 Pixel data SHALL pass unmodified (no arithmetic, no width change).

Reset
REQ-031 res_n=0 SHALL asynchronously force state LOAD, k=0, p=ImageSize-1 and c=0.
REQ-032 During reset, outputs SHALL be in_ready=0, out_valid=0, out_data=0 and frame_done=0.
REQ-033 Image buffer contents SHALL not be reset.
REQ-034 A reset asserted mid-LOAD or mid-SEND SHALL discard the partial frame; after release, loading SHALL restart at image 0.

Structure
REQ-035 The FSM state enum (LOAD, SEND) SHALL live in shared package layer_pkg, alongside the flattening layer's types.
REQ-036 Counter widths SHALL be $clog2-derived local constants.
REQ-037 Storage SHALL be one sub-module, image_buffer: NumOfImages x ImageSize x BitSize registers with a write port and a combinational read port (image index, pixel index).

Verification
Default parameters; image n pixel p = 4n+p.
REQ-038 Load images 0-3 back-to-back -> in_ready falls after the 4th accept; next cycle out_valid=0011 with lanes {3,7}, then 1100 with lanes {11,15}, then p=2 gives {2,6},{10,14}.
REQ-039 Full unstalled frame -> 8 SEND cycles; frame_done high only on the 8th cycle (lanes {8,12}, out_valid=1100); in_ready=1 on the next cycle.
REQ-040 out_stall=1 for 3 cycles at send cycle 3 -> lanes {2,6}/out_valid=0011 held for 4 cycles; frame arrives 3 cycles late with no data loss.
REQ-041 in_valid toggling with gaps in LOAD -> only handshaken vectors are stored; output order is unchanged.
REQ-042 res_n low at send cycle 5 -> outputs 0 immediately; after release, a new 4-image load streams the new data.
REQ-043 NumOfImages=3, NumOfInputs=2 -> in cycle c=1, lane 1 is 0 and out_valid=100.

Source files
------------

// File: rtl/layer_pkg.sv
// Types and constants shared by the flattening and unflattening layers.
package layer_pkg;

   typedef enum logic {
      LOAD = 1'b0,
      SEND = 1'b1
   } layer_state_e;

   typedef enum logic [1:0] {
      FLAT_IDLE   = 2'd0,
      FLAT_GATHER = 2'd1,
      FLAT_EMIT   = 2'd2
   } flat_state_e;

   // Counter width that never collapses to zero for single-entry ranges.
   function automatic int clog2_min1(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/image_buffer.sv
// Frame store for the unflattening layer: one write port for whole images,
// combinational read of one pixel index across several image slots at once.
module image_buffer
   import layer_pkg::*;
#(
   parameter int BitSize     = 4,
   parameter int ImageSize   = 4,
   parameter int NumOfImages = 4,
   parameter int NumRdPorts  = 2,
   localparam int KW = clog2_min1(NumOfImages),
   localparam int PW = clog2_min1(ImageSize)
) (
   input  logic                                    clk,
   input  logic                                    wr_en,
   input  logic [KW-1:0]                           wr_img,
   input  logic [ImageSize-1:0][BitSize-1:0]       wr_data,
   input  logic [NumRdPorts-1:0][KW-1:0]           rd_img,
   input  logic [PW-1:0]                           rd_pix,
   output logic [NumRdPorts-1:0][BitSize-1:0]      rd_data
);

   logic [ImageSize-1:0][BitSize-1:0] mem_q [NumOfImages];
   logic [ImageSize-1:0][BitSize-1:0] mem_d [NumOfImages];

   always_comb begin
      mem_d = mem_q;
      for (int n = 0; n < NumOfImages; n++) begin
         if (wr_en && (wr_img == KW'(n))) mem_d[n] = wr_data;
      end
   end

   // Contents are deliberately left unreset; a frame is always fully reloaded.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   always_comb begin
      rd_data = '0;
      for (int l = 0; l < NumRdPorts; l++) begin
         for (int n = 0; n < NumOfImages; n++) begin
            if (rd_img[l] == KW'(n)) rd_data[l] = mem_q[n][rd_pix];
         end
      end
   end

endmodule

// File: rtl/unflattening_layer.sv
// Collects NumOfImages image vectors, then streams them out pixel by pixel,
// highest pixel first, across NumOfInputs lanes over CyclesPerPixel cycles.
module unflattening_layer
   import layer_pkg::*;
#(
   parameter int BitSize        = 4,
   parameter int ImageSize      = 4,
   parameter int NumOfImages    = 4,
   parameter int NumOfInputs    = 2,
   parameter int CyclesPerPixel = 2
) (
   input  logic                                   clk,
   input  logic                                   res_n,
   input  logic                                   in_valid,
   output logic                                   in_ready,
   input  logic [ImageSize-1:0][BitSize-1:0]      in_data,
   input  logic                                   out_stall,
   output logic [NumOfImages-1:0]                 out_valid,
   output logic [NumOfInputs-1:0][BitSize-1:0]    out_data,
   output logic                                   frame_done,
   output layer_state_e                           state_dbg
);

   localparam int KW = clog2_min1(NumOfImages);
   localparam int PW = clog2_min1(ImageSize);
   localparam int CW = clog2_min1(CyclesPerPixel);

   layer_state_e   state_q, state_d;
   logic [KW-1:0]  k_q, k_d;
   logic [PW-1:0]  p_q, p_d;
   logic [CW-1:0]  c_q, c_d;
   logic           wr_en;
   logic [NumOfInputs-1:0][KW-1:0]      rd_img;
   logic [NumOfInputs-1:0][BitSize-1:0] rd_data;

   // Handshake: an image is taken on a rising edge where in_valid && in_ready.
   // in_ready is gated by res_n so nothing is offered while reset is held.
   assign in_ready  = res_n & (state_q == LOAD);
   assign wr_en     = in_valid & in_ready;
   assign state_dbg = state_q;

   image_buffer #(
      .BitSize     (BitSize),
      .ImageSize   (ImageSize),
      .NumOfImages (NumOfImages),
      .NumRdPorts  (NumOfInputs)
   ) u_buf (
      .clk     (clk),
      .wr_en   (wr_en),
      .wr_img  (k_q),
      .wr_data (in_data),
      .rd_img  (rd_img),
      .rd_pix  (p_q),
      .rd_data (rd_data)
   );

   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         state_q <= LOAD;
         k_q     <= '0;
         p_q     <= PW'(ImageSize - 1);
         c_q     <= '0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         p_q     <= p_d;
         c_q     <= c_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      k_d        = k_q;
      p_d        = p_q;
      c_d        = c_q;
      frame_done = 1'b0;
      case (state_q)
         LOAD: begin
            if (wr_en) begin
               if (k_q == KW'(NumOfImages - 1)) begin
                  k_d     = '0;
                  state_d = SEND;
               end else begin
                  k_d = k_q + 1'b1;
               end
            end
         end
         SEND: begin
            if (!out_stall) begin
               if (c_q == CW'(CyclesPerPixel - 1)) begin
                  c_d = '0;
                  if (p_q == '0) begin
                     frame_done = 1'b1;
                     p_d        = PW'(ImageSize - 1);
                     state_d    = LOAD;
                  end else begin
                     p_d = p_q - 1'b1;
                  end
               end else begin
                  c_d = c_q + 1'b1;
               end
            end
         end
         default: state_d = LOAD;
      endcase
   end

   // Lane l of cycle c shows image c*NumOfInputs+l; slots past the last image stay dark.
   always_comb begin
      out_valid = '0;
      out_data  = '0;
      rd_img    = '0;
      if (state_q == SEND) begin
         for (int l = 0; l < NumOfInputs; l++) begin
            if ((int'(c_q) * NumOfInputs + l) < NumOfImages) begin
               rd_img[l]   = KW'(int'(c_q) * NumOfInputs + l);
               out_data[l] = rd_data[l];
               for (int n = 0; n < NumOfImages; n++) begin
                  if (n == int'(c_q) * NumOfInputs + l) out_valid[n] = 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_unflattening_layer.sv
// Randomized bench for unflattening_layer: expected output streams are built
// from the frame contents with plain pixel/lane arithmetic.
module tb_unflattening_layer;
   import layer_pkg::*;

   localparam int BS   = 4;
   localparam int IS   = 4;
   localparam int NIMG = 4;
   localparam int NI   = 2;
   localparam int CPP  = 2;
   localparam int EW   = 1 + NIMG + NI * BS;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic res_n = 1'b0;
   always #5 clk = ~clk;

   logic                      in_valid, in_ready, out_stall, frame_done;
   logic [IS-1:0][BS-1:0]     in_data;
   logic [NIMG-1:0]           out_valid;
   logic [NI-1:0][BS-1:0]     out_data;
   layer_state_e              state_dbg;

   logic                      in_valid3, in_ready3, out_stall3, frame_done3;
   logic [IS-1:0][BS-1:0]     in_data3;
   logic [2:0]                out_valid3;
   logic [NI-1:0][BS-1:0]     out_data3;
   layer_state_e              state_dbg3;

   unflattening_layer #(
      .BitSize(BS), .ImageSize(IS), .NumOfImages(NIMG),
      .NumOfInputs(NI), .CyclesPerPixel(CPP)
   ) dut (
      .clk(clk), .res_n(res_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .out_stall(out_stall), .out_valid(out_valid),
      .out_data(out_data), .frame_done(frame_done), .state_dbg(state_dbg)
   );

   unflattening_layer #(
      .BitSize(BS), .ImageSize(IS), .NumOfImages(3),
      .NumOfInputs(NI), .CyclesPerPixel(CPP)
   ) dut3 (
      .clk(clk), .res_n(res_n), .in_valid(in_valid3), .in_ready(in_ready3),
      .in_data(in_data3), .out_stall(out_stall3), .out_valid(out_valid3),
      .out_data(out_data3), .frame_done(frame_done3), .state_dbg(state_dbg3)
   );

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_errors = 0;
   logic [EW-1:0] exp_q[$];
   logic [BS-1:0] img_m [NIMG][IS];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Send cycle s covers pixel IS-1-s/CPP, group s%CPP; lane l holds image group*NI+l.
   function automatic void build_expected();
      logic [NIMG-1:0]       v;
      logic [NI-1:0][BS-1:0] d;
      int p, c, n;
      exp_q.delete();
      for (int s = 0; s < IS * CPP; s++) begin
         p = IS - 1 - s / CPP;
         c = s % CPP;
         v = '0;
         d = '0;
         for (int l = 0; l < NI; l++) begin
            n = c * NI + l;
            if (n < NIMG) begin
               v[n] = 1'b1;
               d[l] = img_m[n][p];
            end
         end
         exp_q.push_back({(s == IS * CPP - 1), v, d});
      end
   endfunction

   // ---------------- driver tasks ----------------
   task automatic fill_images(input bit random_data);
      for (int n = 0; n < NIMG; n++)
         for (int p = 0; p < IS; p++)
            img_m[n][p] = random_data ? BS'($urandom_range(0, 2**BS - 1)) : BS'(4 * n + p);
   endtask

   task automatic load_frame(input int count, input bit gaps);
      for (int k = 0; k < count; k++) begin
         if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
               @(negedge clk);
               in_valid  = 1'b0;
               in_data   = (IS*BS)'($urandom);
               out_stall = 1'($urandom_range(0, 1));
               #1;
               check_eq("load_idle_ready", 32'(in_ready), 32'd1);
               check_eq("load_idle_out", 32'({out_valid, out_data}), 32'd0);
            end
         end
         @(negedge clk);
         in_valid  = 1'b1;
         out_stall = gaps ? 1'($urandom_range(0, 1)) : 1'b0;
         for (int p = 0; p < IS; p++) in_data[p] = img_m[k][p];
         #1;
         check_eq("load_ready", 32'(in_ready), 32'd1);
         check_eq("load_out", 32'({out_valid, out_data}), 32'd0);
         check_eq("load_done", 32'(frame_done), 32'd0);
      end
   endtask

   // mode 0: no stall, 1: stall 3 cycles from send cycle index 2, 2: random stalls
   task automatic run_send(input int mode, input int abort_after);
      logic [EW-1:0] e;
      int cycles = 0;
      int stalls = 0;
      int popped = 0;
      while (exp_q.size() > 0) begin
         @(negedge clk);
         in_valid = 1'($urandom_range(0, 1));
         in_data  = (IS*BS)'($urandom);
         case (mode)
            1:       out_stall = (cycles >= 2 && cycles <= 4);
            2:       out_stall = ($urandom_range(0, 3) == 0);
            default: out_stall = 1'b0;
         endcase
         #1;
         e = exp_q[0];
         check_eq("send_valid", 32'(out_valid), 32'(e[NI*BS +: NIMG]));
         check_eq("send_data", 32'(out_data), 32'(e[NI*BS-1:0]));
         check_eq("send_done", 32'(frame_done), 32'(e[EW-1] & ~out_stall));
         check_eq("send_ready", 32'(in_ready), 32'd0);
         cycles++;
         if (out_stall) stalls++;
         else begin
            void'(exp_q.pop_front());
            popped++;
         end
         if (abort_after > 0 && popped == abort_after) break;
         if (cycles > 200) begin
            check_eq("send_timeout", 32'(cycles), 32'd0);
            break;
         end
      end
      if (abort_after == 0) begin
         check_eq("send_len", 32'(cycles), 32'(IS * CPP + stalls));
         if (mode == 1) check_eq("stall_len", 32'(cycles), 32'(IS * CPP + 3));
         @(negedge clk);
         in_valid  = 1'b0;
         out_stall = 1'b0;
         #1;
         check_eq("post_ready", 32'(in_ready), 32'd1);
         check_eq("post_out", 32'({out_valid, out_data}), 32'd0);
      end
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      in_valid = 1'b0;
      res_n    = 1'b0;
      #1;
      check_eq("rst_out", 32'({out_valid, out_data}), 32'd0);
      check_eq("rst_ready", 32'(in_ready), 32'd0);
      check_eq("rst_done", 32'(frame_done), 32'd0);
      check_eq("rst_state", 32'(state_dbg), 32'(LOAD));
      @(negedge clk);
      res_n = 1'b1;
      exp_q.delete();
   endtask

   task automatic run_three_image_dut();
      logic [2:0]            v;
      logic [NI-1:0][BS-1:0] d;
      int p, c, n;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         in_valid3 = 1'b1;
         for (int q = 0; q < IS; q++) in_data3[q] = BS'(4 * k + q);
         #1;
         check_eq("n3_ready", 32'(in_ready3), 32'd1);
      end
      for (int s = 0; s < IS * CPP; s++) begin
         @(negedge clk);
         in_valid3 = 1'b0;
         #1;
         p = IS - 1 - s / CPP;
         c = s % CPP;
         v = '0;
         d = '0;
         for (int l = 0; l < NI; l++) begin
            n = c * NI + l;
            if (n < 3) begin
               v[n] = 1'b1;
               d[l] = BS'(4 * n + p);
            end
         end
         check_eq("n3_valid", 32'(out_valid3), 32'(v));
         check_eq("n3_data", 32'(out_data3), 32'(d));
         check_eq("n3_done", 32'(frame_done3), 32'(s == IS * CPP - 1));
         if (c == 1) begin
            check_eq("n3_lane1_zero", 32'(out_data3[1]), 32'd0);
            check_eq("n3_valid_100", 32'(out_valid3), 32'b100);
         end
      end
      @(negedge clk);
      #1;
      check_eq("n3_post_ready", 32'(in_ready3), 32'd1);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      in_valid   = 1'b0;
      in_data    = '0;
      out_stall  = 1'b0;
      in_valid3  = 1'b0;
      in_data3   = '0;
      out_stall3 = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      check_eq("reset_ready", 32'(in_ready), 32'd0);
      check_eq("reset_out", 32'({out_valid, out_data}), 32'd0);
      check_eq("reset_done", 32'(frame_done), 32'd0);
      check_eq("reset_ready3", 32'(in_ready3), 32'd0);
      @(negedge clk);
      res_n = 1'b1;
      #1;
      check_eq("release_ready", 32'(in_ready), 32'd1);

      fill_images(1'b0);
      load_frame(NIMG, 1'b0);
      build_expected();
      run_send(0, 0);

      fill_images(1'b0);
      load_frame(NIMG, 1'b0);
      build_expected();
      run_send(1, 0);

      fill_images(1'b1);
      load_frame(NIMG, 1'b1);
      build_expected();
      run_send(2, 0);

      fill_images(1'b1);
      load_frame(2, 1'b0);
      pulse_reset();
      fill_images(1'b1);
      load_frame(NIMG, 1'b0);
      build_expected();
      run_send(0, 0);

      fill_images(1'b0);
      load_frame(NIMG, 1'b0);
      build_expected();
      run_send(0, 5);
      pulse_reset();
      fill_images(1'b1);
      load_frame(NIMG, 1'b0);
      build_expected();
      run_send(0, 0);

      for (int i = 0; i < 3; i++) begin
         fill_images(1'b1);
         load_frame(NIMG, 1'b1);
         build_expected();
         run_send(2, 0);
      end

      run_three_image_dut();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
      $fatal(1);
   end

endmodule
